// File: rtl/jtpopeye_pkg.sv
// Shared types for the Popeye SDRAM read arbiter: requester ids, FSM states
// and SDRAM word-address helpers.
package jtpopeye_pkg;

   localparam int SDRAM_AW = 22;
   localparam int TAG_W    = 13;

   typedef enum logic {
      REQ_MAIN = 1'b0,
      REQ_OBJ  = 1'b1
   } req_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_DATA
   } state_e;

   // A tag names a 32-bit word, i.e. two 16-bit SDRAM words; the sum wraps mod 2^22.
   function automatic logic [SDRAM_AW-1:0] word_addr(input logic [SDRAM_AW-1:0] base,
                                                      input logic [TAG_W-1:0]    tag);
      return base + {{(SDRAM_AW-TAG_W-1){1'b0}}, tag, 1'b0};
   endfunction

endpackage

// File: rtl/jtpopeye_rom_cache.sv
// One-entry read cache: holds the last word fetched for a requester and
// reports a hit when the live tag matches the stored one.
module jtpopeye_rom_cache #(
   parameter int TAG_W  = 13,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TAG_W-1:0]  tag,
   input  logic              load,
   input  logic [TAG_W-1:0]  load_tag,
   input  logic [DATA_W-1:0] load_data,
   output logic              hit,
   output logic [DATA_W-1:0] word
);

   logic             valid;
   logic [TAG_W-1:0] tag_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         tag_q <= '0;
         word  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         tag_q <= load_tag;
         word  <= load_data;
      end
   end

   assign hit = valid && (tag == tag_q);

endmodule

// File: rtl/jtpopeye_sdram_arb.sv
// Read-only SDRAM arbiter between the main CPU ROM and the object-ROM fetcher.
// Each side keeps its last word cached; only misses go out to the SDRAM.
module jtpopeye_sdram_arb
   import jtpopeye_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] MAIN_OFFSET = 22'h000000,
   parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h008000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                main_cs,
   input  logic [14:0]         main_addr,
   output logic [7:0]          main_dout,
   output logic                main_ok,
   input  logic [TAG_W-1:0]    obj_addr,
   output logic [31:0]         objrom_data,
   output logic                obj_ok,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [31:0]         data_read
);

   state_e              state, state_nx;
   req_e                gnt, gnt_nx, last_served, last_nx, pick;
   logic [TAG_W-1:0]    issue_tag, tag_nx;
   logic                req_nx;
   logic [SDRAM_AW-1:0] addr_nx;
   logic                main_load, obj_load, main_hit, obj_hit, main_miss, obj_miss;
   logic [31:0]         main_word;

   jtpopeye_rom_cache #(.TAG_W(TAG_W), .DATA_W(32)) u_main (
      .clk       (clk),
      .rst_n     (rst_n),
      .tag       (main_addr[14:2]),
      .load      (main_load),
      .load_tag  (issue_tag),
      .load_data (data_read),
      .hit       (main_hit),
      .word      (main_word)
   );

   jtpopeye_rom_cache #(.TAG_W(TAG_W), .DATA_W(32)) u_obj (
      .clk       (clk),
      .rst_n     (rst_n),
      .tag       (obj_addr),
      .load      (obj_load),
      .load_tag  (issue_tag),
      .load_data (data_read),
      .hit       (obj_hit),
      .word      (objrom_data)
   );

   assign main_ok   = main_cs && main_hit;
   assign obj_ok    = obj_hit;
   assign main_dout = main_word[{main_addr[1:0], 3'b000} +: 8];
   assign main_miss = main_cs && !main_ok;
   assign obj_miss  = !obj_ok;

   // Round robin only matters when both miss; otherwise serve whoever does.
   always_comb begin
      pick = REQ_MAIN;
      if (main_miss && obj_miss)
         pick = (last_served == REQ_MAIN) ? REQ_OBJ : REQ_MAIN;
      else if (obj_miss)
         pick = REQ_OBJ;
   end

   always_comb begin
      state_nx  = state;
      gnt_nx    = gnt;
      tag_nx    = issue_tag;
      last_nx   = last_served;
      req_nx    = sdram_req;
      addr_nx   = sdram_addr;
      main_load = 1'b0;
      obj_load  = 1'b0;
      case (state)
         IDLE: begin
            if (main_miss || obj_miss) begin
               gnt_nx   = pick;
               tag_nx   = (pick == REQ_OBJ) ? obj_addr : main_addr[14:2];
               req_nx   = 1'b1;
               addr_nx  = (pick == REQ_OBJ) ? word_addr(OBJ_OFFSET, obj_addr)
                                            : word_addr(MAIN_OFFSET, main_addr[14:2]);
               state_nx = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (sdram_ack) begin
               req_nx   = 1'b0;
               state_nx = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            // Stored under the tag that was issued, even if the address moved since.
            if (data_rdy) begin
               main_load = (gnt == REQ_MAIN);
               obj_load  = (gnt == REQ_OBJ);
               last_nx   = gnt;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt         <= REQ_MAIN;
         last_served <= REQ_MAIN;
         issue_tag   <= '0;
         sdram_req   <= 1'b0;
         sdram_addr  <= '0;
      end else begin
         state       <= state_nx;
         gnt         <= gnt_nx;
         last_served <= last_nx;
         issue_tag   <= tag_nx;
         sdram_req   <= req_nx;
         sdram_addr  <= addr_nx;
      end
   end

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// Directed bench for jtpopeye_sdram_arb: expected SDRAM addresses are queued
// as stimulus is set up and popped when the arbiter raises sdram_req.
module tb_jtpopeye_sdram_arb;
   import jtpopeye_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        main_cs;
   logic [14:0] main_addr;
   logic [7:0]  main_dout;
   logic        main_ok;
   logic [12:0] obj_addr;
   logic [31:0] objrom_data;
   logic        obj_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack;
   logic        data_rdy;
   logic [31:0] data_read;

   int          checks = 0;
   int          errors = 0;
   logic [21:0] exp_q[$];

   always #5 clk = ~clk;

   jtpopeye_sdram_arb dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .main_cs     (main_cs),
      .main_addr   (main_addr),
      .main_dout   (main_dout),
      .main_ok     (main_ok),
      .obj_addr    (obj_addr),
      .objrom_data (objrom_data),
      .obj_ok      (obj_ok),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_rdy    (data_rdy),
      .data_read   (data_read)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for a request, match it against the scoreboard, hold it, then acknowledge.
   task automatic grant_ack();
      int          n = 0;
      logic [21:0] e;
      while (sdram_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("req_seen", 32'(sdram_req), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 22'h3FFFFF;
      check("req_addr", 32'(sdram_addr), 32'(e));
      step();
      step();
      check("req_hold", {9'd0, sdram_req, sdram_addr}, {9'd0, 1'b1, e});
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      check("req_drop", 32'(sdram_req), 32'd0);
   endtask

   task automatic deliver(input logic [31:0] d);
      step();
      data_read = d;
      data_rdy  = 1'b1;
      step();
      data_rdy  = 1'b0;
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      main_cs   = 1'b0;
      main_addr = '0;
      obj_addr  = 13'h0010;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      data_read = '0;
      step();
      step();
      check("rst_req",  32'(sdram_req), 32'd0);
      check("rst_addr", 32'(sdram_addr), 32'd0);
      check("rst_ok",   {30'd0, main_ok, obj_ok}, 32'd0);
      check("rst_data", objrom_data, 32'd0);
      check("rst_dout", 32'(main_dout), 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));

      // Both miss after reset with last_served=MAIN: obj first, main right after.
      main_cs   = 1'b1;
      main_addr = 15'h0005;
      exp_q.push_back(22'h008020);
      exp_q.push_back(22'h000002);
      rst_n = 1'b1;
      grant_ack();
      deliver(32'h12345678);
      check("obj_ok",   32'(obj_ok), 32'd1);
      check("obj_data", objrom_data, 32'h12345678);
      check("main_still_miss", 32'(main_ok), 32'd0);
      check("idle_after_data", 32'(sdram_req), 32'd0);
      step();
      check("rr_next_cycle", 32'(sdram_req), 32'd1);
      grant_ack();
      deliver(32'hDDCCBBAA);
      check("main_ok",   32'(main_ok), 32'd1);
      check("main_byte1", 32'(main_dout), 32'h000000BB);
      main_addr = 15'h0007;
      #1;
      check("main_byte3", 32'(main_dout), 32'h000000DD);
      for (int i = 0; i < 5; i++) begin
         step();
         check("main_hit_no_req", 32'(sdram_req), 32'd0);
      end

      // Address moves while the fetch is in WAIT_DATA.
      main_cs  = 1'b0;
      obj_addr = 13'h0020;
      exp_q.push_back(22'h008040);
      grant_ack();
      deliver(32'hAAAA0020);
      check("obj20_data", objrom_data, 32'hAAAA0020);
      obj_addr = 13'h0010;
      exp_q.push_back(22'h008020);
      grant_ack();
      obj_addr = 13'h0011;
      deliver(32'hCAFEF00D);
      check("moved_ok_low", 32'(obj_ok), 32'd0);
      obj_addr = 13'h0010;
      #1;
      check("issue_tag_hit",  32'(obj_ok), 32'd1);
      check("issue_tag_data", objrom_data, 32'hCAFEF00D);
      obj_addr = 13'h0011;
      exp_q.push_back(22'h008022);
      grant_ack();
      deliver(32'h11111111);
      check("obj11_ok",   32'(obj_ok), 32'd1);
      check("obj11_data", objrom_data, 32'h11111111);

      // Reset during WAIT_DATA, then a stray data_rdy on the first live cycle.
      obj_addr = 13'h0030;
      exp_q.push_back(22'h008060);
      grant_ack();
      rst_n = 1'b0;
      step();
      check("midrst_req",   32'(sdram_req), 32'd0);
      check("midrst_ok",    {30'd0, main_ok, obj_ok}, 32'd0);
      check("midrst_state", 32'(dut.state), 32'(IDLE));
      rst_n     = 1'b1;
      data_read = 32'hBAD0BAD0;
      data_rdy  = 1'b1;
      step();
      data_rdy  = 1'b0;
      #1;
      check("stray_ok",    32'(obj_ok), 32'd0);
      check("stray_data",  objrom_data, 32'd0);
      check("stray_state", 32'(dut.state), 32'(WAIT_ACK));
      exp_q.push_back(22'h008060);
      grant_ack();
      deliver(32'h60606060);
      check("obj30_data", objrom_data, 32'h60606060);

      // Refill main, then both hit for a long stretch with no SDRAM traffic.
      main_cs = 1'b1;
      exp_q.push_back(22'h000002);
      grant_ack();
      deliver(32'hDDCCBBAA);
      check("main_refill", 32'(main_dout), 32'h000000DD);
      for (int i = 0; i < 100; i++) begin
         step();
         check("both_hit", {29'd0, sdram_req, main_ok, obj_ok}, 32'd3);
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
